led_blink_bank: RTL and testbench

//  - N independent LED channels with runtime-configurable mode and period.
//  - Shared prescaler produces a base tick; each channel counts ticks for OFF/ON/BLINK/ONESHOT.
//  - Sits between board top-level and LED pins; config written via valid/ready port (UART/host FSM).

---
 rtl/led_blink_bank_pkg.sv | 26 ++
 rtl/led_blink_bank_channel.sv | 91 +++++++++
 rtl/led_blink_bank.sv | 126 ++++++++++++
 tb/tb_led_blink_bank.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_bank_pkg.sv
// Shared definitions for the LED blink bank: channel modes, field widths
// and the PWM gating helper. The optional brightness feature is enabled by
// defining LED_PWM_EN; this package is the same in both builds.
package led_blink_bank_pkg;

  localparam int MODE_W = 2;
  localparam int DUTY_W = 4;

  // Full-scale duty keeps the LED lit on every PWM slot.
  localparam logic [DUTY_W-1:0] DUTY_FULL = 4'hF;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } led_mode_e;

  // Lit-phase gate: full duty is solid on, otherwise on while the PWM count
  // is below the duty value (duty 0 therefore never lights).
  function automatic logic pwm_gate(input logic [DUTY_W-1:0] duty,
                                    input logic [DUTY_W-1:0] cnt);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/led_blink_bank_channel.sv
// One LED channel: holds its mode, period, tick counter and on/off phase.
// A load strobe from the bank commits a new configuration and always beats
// a coincident tick. With LED_PWM_EN defined the channel also keeps a duty
// value and gates its lit phase with the bank's shared PWM counter.
module led_blink_bank_channel
  import led_blink_bank_pkg::*;
#(
  parameter int PERIOD_W = 10
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                tick,
  input  logic                load,
  input  led_mode_e           cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
`ifdef LED_PWM_EN
  input  logic [DUTY_W-1:0]   cfg_duty,
  input  logic [DUTY_W-1:0]   pwm_cnt,
`endif
  output logic                led
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  led_mode_e           mode_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] count_reg;
  logic                phase_reg;
  logic [PERIOD_W-1:0] last_count;

  // A stored period of 0 behaves as 1, so the terminal count is 0 as well.
  assign last_count = (period_reg == '0) ? '0 : (period_reg - ONE);

  // Mode/phase state machine: commit, then tick-driven blink or one-shot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_reg   <= MODE_OFF;
      period_reg <= '0;
      count_reg  <= '0;
      phase_reg  <= 1'b0;
    end else if (load) begin
      mode_reg   <= cfg_mode;
      period_reg <= cfg_period;
      count_reg  <= '0;
      phase_reg  <= (cfg_mode != MODE_OFF);
    end else if (tick) begin
      case (mode_reg)
        MODE_BLINK: begin
          // Compare before incrementing so the counter never wraps.
          if (count_reg == last_count) begin
            count_reg <= '0;
            phase_reg <= ~phase_reg;
          end else begin
            count_reg <= count_reg + ONE;
          end
        end
        MODE_ONESHOT: begin
          // After the on-time expires the channel parks itself in OFF.
          if (count_reg == last_count) begin
            count_reg <= '0;
            phase_reg <= 1'b0;
            mode_reg  <= MODE_OFF;
          end else begin
            count_reg <= count_reg + ONE;
          end
        end
        default: begin
          // OFF and ON keep their counters idle.
        end
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [DUTY_W-1:0] duty_reg;

  // Brightness is captured with every commit and returns to full on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      duty_reg <= DUTY_FULL;
    end else if (load) begin
      duty_reg <= cfg_duty;
    end
  end

  assign led = phase_reg && (mode_reg != MODE_OFF) && pwm_gate(duty_reg, pwm_cnt);
`else
  assign led = phase_reg && (mode_reg != MODE_OFF);
`endif

endmodule

// File: rtl/led_blink_bank.sv
// Bank of independent LED channels sharing one base-tick prescaler.
// The host writes one channel configuration at a time over a valid/ready
// port; each accepted write is committed on the following cycle, during
// which the port reports not-ready. Defining LED_PWM_EN adds the CFG_DUTY
// port and a free-running 4-bit PWM counter for per-channel brightness.
module led_blink_bank
  import led_blink_bank_pkg::*;
#(
  parameter  int N_LEDS   = 4,
  parameter  int PRESCALE = 12000,
  parameter  int PERIOD_W = 10,
  localparam int CH_W     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CFG_VALID,
  output logic                CFG_READY,
  input  logic [CH_W-1:0]     CFG_CH,
  input  logic [MODE_W-1:0]   CFG_MODE,
  input  logic [PERIOD_W-1:0] CFG_PERIOD,
`ifdef LED_PWM_EN
  input  logic [DUTY_W-1:0]   CFG_DUTY,
`endif
  output logic                TICK,
  output logic [N_LEDS-1:0]   LED
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_PRE  = PS_W'(PRESCALE - 2);

  logic [PS_W-1:0]     ps_cnt_reg;
  logic                tick_reg;
  logic                ready_reg;
  logic                commit_reg;
  logic [CH_W-1:0]     cfg_ch_reg;
  led_mode_e           cfg_mode_reg;
  logic [PERIOD_W-1:0] cfg_period_reg;
  logic                accept;

  assign accept    = CFG_VALID && ready_reg;
  assign CFG_READY = ready_reg;
  assign TICK      = tick_reg;

  // Prescaler: TICK is registered so it is high exactly while the count
  // sits at its terminal value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ps_cnt_reg <= '0;
      tick_reg   <= 1'b0;
    end else begin
      ps_cnt_reg <= (ps_cnt_reg == PS_LAST) ? '0 : (ps_cnt_reg + PS_ONE);
      tick_reg   <= (ps_cnt_reg == PS_PRE);
    end
  end

  // Handshake: capture the write, then spend one not-ready cycle committing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ready_reg      <= 1'b0;
      commit_reg     <= 1'b0;
      cfg_ch_reg     <= '0;
      cfg_mode_reg   <= MODE_OFF;
      cfg_period_reg <= '0;
    end else begin
      ready_reg  <= !accept;
      commit_reg <= accept;
      if (accept) begin
        cfg_ch_reg     <= CFG_CH;
        cfg_mode_reg   <= led_mode_e'(CFG_MODE);
        cfg_period_reg <= CFG_PERIOD;
      end
    end
  end

`ifdef LED_PWM_EN
  logic [DUTY_W-1:0] cfg_duty_reg;
  logic [DUTY_W-1:0] pwm_cnt_reg;

  // Duty travels with the rest of the captured write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_duty_reg <= DUTY_FULL;
    end else if (accept) begin
      cfg_duty_reg <= CFG_DUTY;
    end
  end

  // Free-running PWM slot counter shared by all channels.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + DUTY_W'(1);
    end
  end
`endif

  // Channel decode: an out-of-range channel matches no slot, so the write
  // handshakes normally and is simply dropped.
  genvar gi;
  generate
    for (gi = 0; gi < N_LEDS; gi++) begin : g_ch
      logic load;
      assign load = commit_reg && (cfg_ch_reg == CH_W'(gi));

      led_blink_bank_channel #(
        .PERIOD_W (PERIOD_W)
      ) u_ch (
        .CLK        (CLK),
        .RST        (RST),
        .tick       (tick_reg),
        .load       (load),
        .cfg_mode   (cfg_mode_reg),
        .cfg_period (cfg_period_reg),
`ifdef LED_PWM_EN
        .cfg_duty   (cfg_duty_reg),
        .pwm_cnt    (pwm_cnt_reg),
`endif
        .led        (LED[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_blink_bank.sv
// Bench for led_blink_bank (N_LEDS=4, PRESCALE=4, PERIOD_W=4) plus a
// 3-channel instance on the same stimulus so channel 3 is out of range there.
// The reference model tracks, per channel, the mode and the number of ticks
// seen since the last commit, and derives the LED from those counts.
module tb_led_blink_bank;

  localparam int P  = 4;
  localparam int PW = 4;
  localparam int M_OFF = 0, M_ON = 1, M_BLINK = 2, M_ONESHOT = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CFG_VALID = 1'b0;
  logic [1:0]    CFG_CH = '0;
  logic [1:0]    CFG_MODE = '0;
  logic [PW-1:0] CFG_PERIOD = '0;
  logic [3:0]    CFG_DUTY = 4'hF;

  logic       ready4, tick4, ready3, tick3;
  logic [3:0] led4;
  logic [2:0] led3;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int cyc;
  bit pend, acc;
  int pch, pmode, pper, pduty;
  int m_mode[2][4];
  int m_per[2][4];
  int m_k[2][4];
  int m_duty[2][4];
  int nl[2] = '{4, 3};

  always #5 CLK = ~CLK;

  led_blink_bank #(.N_LEDS(4), .PRESCALE(P), .PERIOD_W(PW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CFG_VALID  (CFG_VALID),
    .CFG_READY  (ready4),
    .CFG_CH     (CFG_CH),
    .CFG_MODE   (CFG_MODE),
    .CFG_PERIOD (CFG_PERIOD),
`ifdef LED_PWM_EN
    .CFG_DUTY   (CFG_DUTY),
`endif
    .TICK       (tick4),
    .LED        (led4)
  );

  led_blink_bank #(.N_LEDS(3), .PRESCALE(P), .PERIOD_W(PW)) dut3 (
    .CLK        (CLK),
    .RST        (RST),
    .CFG_VALID  (CFG_VALID),
    .CFG_READY  (ready3),
    .CFG_CH     (CFG_CH),
    .CFG_MODE   (CFG_MODE),
    .CFG_PERIOD (CFG_PERIOD),
`ifdef LED_PWM_EN
    .CFG_DUTY   (CFG_DUTY),
`endif
    .TICK       (tick3),
    .LED        (led3)
  );

  task automatic model_reset();
    cyc  = 0;
    pend = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) begin
        m_mode[i][c] = M_OFF;
        m_per[i][c]  = 1;
        m_k[i][c]    = 0;
        m_duty[i][c] = 15;
      end
  endtask

  // Apply one clock edge to the model using the inputs present before it.
  task automatic model_edge();
    bit tk, rdy;
    acc = 1'b0;
    if (RST) begin
      model_reset();
      return;
    end
    tk  = (cyc % P) == (P - 1);
    rdy = (cyc > 0) && !pend;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < nl[i]; c++) begin
        if (pend && pch == c) begin
          m_mode[i][c] = pmode;
          m_per[i][c]  = (pper == 0) ? 1 : pper;
          m_k[i][c]    = 0;
          m_duty[i][c] = pduty;
        end else if (tk && (m_mode[i][c] == M_BLINK || m_mode[i][c] == M_ONESHOT)) begin
          m_k[i][c]++;
          if (m_mode[i][c] == M_ONESHOT && m_k[i][c] >= m_per[i][c]) m_mode[i][c] = M_OFF;
        end
      end
    pend = CFG_VALID && rdy;
    if (pend) begin
      acc   = 1'b1;
      pch   = int'(CFG_CH);
      pmode = int'(CFG_MODE);
      pper  = int'(CFG_PERIOD);
      pduty = int'(CFG_DUTY);
    end
    cyc++;
  endtask

  function automatic logic exp_led(int inst, int ch);
    logic lit;
    int md, k, p;
    md  = m_mode[inst][ch];
    k   = m_k[inst][ch];
    p   = m_per[inst][ch];
    lit = (md == M_ON) || (md == M_BLINK && ((k / p) % 2) == 0) || (md == M_ONESHOT && k < p);
`ifdef LED_PWM_EN
    lit = lit && (m_duty[inst][ch] == 15 || (cyc % 16) < m_duty[inst][ch]);
`endif
    return lit;
  endfunction

  task automatic cmp(string tag, logic [3:0] obs, logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check();
    logic [3:0] e4;
    logic [2:0] e3;
    logic et, er;
    et = (cyc % P) == (P - 1);
    er = (cyc > 0) && !pend;
    for (int c = 0; c < 4; c++) e4[c] = exp_led(0, c);
    for (int c = 0; c < 3; c++) e3[c] = exp_led(1, c);
    cmp("tick4",  4'(tick4),  4'(et));
    cmp("ready4", 4'(ready4), 4'(er));
    cmp("led4",   led4,       e4);
    cmp("tick3",  4'(tick3),  4'(et));
    cmp("ready3", 4'(ready3), 4'(er));
    cmp("led3",   4'(led3),   4'(e3));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present a write and hold VALID until the edge that accepts it.
  task automatic do_write(int ch, int mode, int per, int duty);
    int n;
    n = 0;
    CFG_VALID  = 1'b1;
    CFG_CH     = 2'(ch);
    CFG_MODE   = 2'(mode);
    CFG_PERIOD = PW'(per);
    CFG_DUTY   = 4'(duty);
    do begin
      step();
      n++;
    end while (!acc && n < 20);
    CFG_VALID = 1'b0;
    $display("write ch=%0d mode=%0d period=%0d duty=%0d accepted=%0d at cycle %0d",
             ch, mode, per, duty, acc, cyc);
  endtask

  initial begin
    int guard;
    model_reset();

    // Reset held three cycles, then prescaler/ready bring-up
    RST = 1'b1;
    run(3);
    RST = 1'b0;
    run(12);

    // ch1 BLINK period 3, five full cycles
    do_write(1, M_BLINK, 3, 15);
    run(2 * 3 * P * 5);

    // ch2 ONESHOT period 2, then dark for 20 ticks
    do_write(2, M_ONESHOT, 2, 15);
    run(P * 22);

    // ch3 ON, then back-to-back write with VALID held (ch3 invalid on dut3)
    do_write(3, M_ON, 1, 15);
    do_write(3, M_BLINK, 2, 15);
    run(40);

    // Commit lands in a TICK cycle: valid presented when count is P-2
    guard = 0;
    while ((cyc % P) != (P - 2) && guard < 8) begin
      step();
      guard++;
    end
    do_write(1, M_BLINK, 1, 15);
    run(20);

    // Reset in the middle of blinking
    RST = 1'b1;
    run(1);
    RST = 1'b0;
    run(8);

`ifdef LED_PWM_EN
    do_write(0, M_ON, 0, 4);
    run(32);
    do_write(0, M_ON, 0, 15);
    run(20);
    do_write(0, M_ON, 0, 0);
    run(20);
`endif

    // Randomized writes with occasional resets
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 14) == 0) begin
        RST = 1'b1;
        run(1);
        RST = 1'b0;
      end
      do_write($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 5), $urandom_range(0, 15));
      run($urandom_range(1, 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
